// File: rtl/ps2_host_tx_if.sv
// Host-side signal bundle for the PS/2 transmitter: byte handshake, line levels and
// open-drain enables, and completion status.
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       ps2_clk_in;
  logic       ps2_data_in;
  logic       ps2_clk_oe;
  logic       ps2_data_oe;
  logic       tx_done;
  logic       tx_err;

  modport master (
    output tx_data, tx_valid, ps2_clk_in, ps2_data_in,
    input  tx_ready, ps2_clk_oe, ps2_data_oe, tx_done, tx_err
  );

  modport slave (
    input  tx_data, tx_valid, ps2_clk_in, ps2_data_in,
    output tx_ready, ps2_clk_oe, ps2_data_oe, tx_done, tx_err
  );
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte transmitter: clock inhibit, request-to-send, frame shifted
// out on device clock falling edges, ACK capture, with an overall transfer timeout.
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYC = 10000,
  parameter int unsigned TIMEOUT_CYC = 2000000
) (
  input  logic         CLK,
  input  logic         RSTN,
  ps2_host_tx_if.slave bus
);
  localparam int unsigned InhW = (INHIBIT_CYC > 1) ? $clog2(INHIBIT_CYC) : 1;
  localparam int unsigned ToW  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  typedef enum logic [2:0] {
    StIdle, StInhibit, StRts, StSend, StAck, StWaitIdle
  } state_e;

  state_e          r_state, w_state_nxt;
  logic [7:0]      r_data, w_data_nxt;
  logic [InhW-1:0] r_inh_cnt, w_inh_cnt_nxt;
  logic [ToW-1:0]  r_to_cnt, w_to_cnt_nxt;
  logic [3:0]      r_bit_cnt, w_bit_cnt_nxt;
  logic            r_nack, w_nack_nxt;
  logic            r_clk_prev;
  logic            r_clk_oe, w_clk_oe_nxt;
  logic            r_data_oe, w_data_oe_nxt;
  logic            r_done, w_done_nxt;
  logic            r_err, w_err_nxt;
  logic            r_ready, w_ready_nxt;

  logic w_fall, w_timeout, w_inh_last, w_active;

  assign w_fall     = r_clk_prev & ~bus.ps2_clk_in;
  assign w_timeout  = (r_to_cnt == ToW'(TIMEOUT_CYC - 1));
  assign w_inh_last = (r_inh_cnt == InhW'(INHIBIT_CYC - 1));
  assign w_active   = (r_state == StRts) || (r_state == StSend) ||
                      (r_state == StAck) || (r_state == StWaitIdle);

  always_comb begin
    w_state_nxt   = r_state;
    w_data_nxt    = r_data;
    w_inh_cnt_nxt = '0;
    w_to_cnt_nxt  = '0;
    w_bit_cnt_nxt = r_bit_cnt;
    w_nack_nxt    = r_nack;
    w_data_oe_nxt = r_data_oe;
    w_done_nxt    = 1'b0;
    w_err_nxt     = 1'b0;

    unique case (r_state)
      StIdle: begin
        w_bit_cnt_nxt = '0;
        w_nack_nxt    = 1'b0;
        if (bus.tx_valid && r_ready) begin
          w_data_nxt  = bus.tx_data;
          w_state_nxt = StInhibit;
        end
      end
      StInhibit: begin
        if (w_inh_last) w_state_nxt = StRts;
        else            w_inh_cnt_nxt = r_inh_cnt + InhW'(1);
      end
      StRts: begin
        w_to_cnt_nxt = r_to_cnt + ToW'(1);
        w_state_nxt  = StSend;
      end
      StSend: begin
        w_to_cnt_nxt = r_to_cnt + ToW'(1);
        if (w_fall) begin
          w_bit_cnt_nxt = r_bit_cnt + 4'd1;
          // Line level is the inverse of the enable: data bits, then odd parity, then stop.
          if (r_bit_cnt < 4'd8) begin
            w_data_oe_nxt = ~r_data[r_bit_cnt[2:0]];
          end else if (r_bit_cnt == 4'd8) begin
            w_data_oe_nxt = ^r_data;
          end else begin
            w_data_oe_nxt = 1'b0;
            w_state_nxt   = StAck;
          end
        end
      end
      StAck: begin
        w_to_cnt_nxt = r_to_cnt + ToW'(1);
        if (w_fall) begin
          w_nack_nxt  = bus.ps2_data_in;
          w_state_nxt = StWaitIdle;
        end
      end
      StWaitIdle: begin
        w_to_cnt_nxt = r_to_cnt + ToW'(1);
        if (bus.ps2_clk_in && bus.ps2_data_in) begin
          w_done_nxt  = 1'b1;
          w_err_nxt   = r_nack;
          w_state_nxt = StIdle;
        end
      end
      default: w_state_nxt = StIdle;
    endcase

    if (w_active && w_timeout) begin
      w_state_nxt  = StIdle;
      w_done_nxt   = 1'b1;
      w_err_nxt    = 1'b1;
      w_to_cnt_nxt = '0;
    end

    // Enables are derived from the next state so they register in step with it.
    w_clk_oe_nxt = (w_state_nxt == StInhibit) || (w_state_nxt == StRts);
    if (w_state_nxt == StRts)       w_data_oe_nxt = 1'b1;
    else if (w_state_nxt != StSend) w_data_oe_nxt = 1'b0;
    w_ready_nxt = (w_state_nxt == StIdle);
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_state    <= StIdle;
      r_data     <= '0;
      r_inh_cnt  <= '0;
      r_to_cnt   <= '0;
      r_bit_cnt  <= '0;
      r_nack     <= 1'b0;
      r_clk_prev <= 1'b1;
      r_clk_oe   <= 1'b0;
      r_data_oe  <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_ready    <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_data     <= w_data_nxt;
      r_inh_cnt  <= w_inh_cnt_nxt;
      r_to_cnt   <= w_to_cnt_nxt;
      r_bit_cnt  <= w_bit_cnt_nxt;
      r_nack     <= w_nack_nxt;
      r_clk_prev <= bus.ps2_clk_in;
      r_clk_oe   <= w_clk_oe_nxt;
      r_data_oe  <= w_data_oe_nxt;
      r_done     <= w_done_nxt;
      r_err      <= w_err_nxt;
      r_ready    <= w_ready_nxt;
    end
  end

  assign bus.tx_ready    = r_ready;
  assign bus.ps2_clk_oe  = r_clk_oe;
  assign bus.ps2_data_oe = r_data_oe;
  assign bus.tx_done     = r_done;
  assign bus.tx_err      = r_err;
endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed-plus-random bench for ps2_host_tx: a PS/2 device model on wired-AND lines,
// frame expectations computed from the byte, and a tx_done monitor.
module tb_ps2_host_tx;
  localparam int unsigned InhCyc = 10000;
  localparam int unsigned ToCyc  = 5000;

  logic CLK = 1'b0;
  logic RSTN = 1'b0;
  logic dev_clk = 1'b1;
  logic dev_data = 1'b1;

  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   done_cnt = 0;
  int   done_cyc = 0;
  logic last_err = 1'b0;
  logic done_clk_oe = 1'b0;
  logic done_data_oe = 1'b0;

  ps2_host_tx_if bus ();

  // Open-drain lines: low if either side pulls.
  assign bus.ps2_clk_in  = ~bus.ps2_clk_oe & dev_clk;
  assign bus.ps2_data_in = ~bus.ps2_data_oe & dev_data;

  ps2_host_tx #(
    .INHIBIT_CYC (InhCyc),
    .TIMEOUT_CYC (ToCyc)
  ) dut (
    .CLK  (CLK),
    .RSTN (RSTN),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (bus.tx_done) begin
      done_cnt++;
      last_err     = bus.tx_err;
      done_cyc     = cyc;
      done_clk_oe  = bus.ps2_clk_oe;
      done_data_oe = bus.ps2_data_oe;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(negedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Line levels a device should see: start, data LSB first, odd parity, stop.
  function automatic logic [10:0] model_frame(input logic [7:0] d);
    logic [10:0] f;
    f[0]   = 1'b0;
    f[8:1] = d;
    f[9]   = (($countones(d) % 2) == 0);
    f[10]  = 1'b1;
    return f;
  endfunction

  task automatic send_req(input logic [7:0] d);
    chk("ready_before_req", {31'd0, bus.tx_ready}, 32'd1);
    bus.tx_data  = d;
    bus.tx_valid = 1'b1;
    tick();
    bus.tx_valid = 1'b0;
  endtask

  task automatic wait_rts(output int inh, output int rts, output int rts_cyc);
    inh = 0;
    rts = 0;
    for (int i = 0; i < int'(InhCyc) + 100 && bus.ps2_clk_oe && !bus.ps2_data_oe; i++) begin
      inh++;
      tick();
    end
    rts_cyc = cyc;
    while (rts < 10 && bus.ps2_clk_oe && bus.ps2_data_oe) begin
      rts++;
      tick();
    end
  endtask

  // Device clocks n_edges falling edges; edge 11 is the ACK edge.
  task automatic device_frame(input int hp, input bit ack, input int n_edges,
                              output logic [10:0] seen);
    seen = '0;
    repeat (hp) tick();
    seen[0] = bus.ps2_data_in;
    for (int k = 1; k <= n_edges && k <= 10; k++) begin
      dev_clk = 1'b0;
      repeat (hp) tick();
      seen[k] = bus.ps2_data_in;
      dev_clk = 1'b1;
      repeat (hp) tick();
    end
    if (n_edges > 10) begin
      dev_data = ack ? 1'b0 : 1'b1;
      dev_clk  = 1'b0;
      repeat (hp) tick();
      dev_clk = 1'b1;
      repeat (hp) tick();
      dev_data = 1'b1;
    end
  endtask

  task automatic wait_done(input string tag, input int start, input int bound);
    int i = 0;
    while (done_cnt == start && i < bound) begin
      tick();
      i++;
    end
    chk(tag, done_cnt - start, 32'd1);
  endtask

  task automatic full_xfer(input string tag, input logic [7:0] d, input bit ack,
                           input logic exp_err);
    int inh, rts, rts_cyc, hp, start;
    logic [10:0] seen, exp;
    hp    = int'($urandom_range(3, 12));
    start = done_cnt;
    exp   = model_frame(d);
    send_req(d);
    wait_rts(inh, rts, rts_cyc);
    chk({tag, "_inhibit_len"}, inh, InhCyc);
    chk({tag, "_rts_len"}, rts, 32'd1);
    device_frame(hp, ack, 11, seen);
    chk({tag, "_frame"}, {21'd0, seen}, {21'd0, exp});
    wait_done({tag, "_done"}, start, 100);
    chk({tag, "_err"}, {31'd0, last_err}, {31'd0, exp_err});
    tick();
    chk({tag, "_ready_after"}, {31'd0, bus.tx_ready}, 32'd1);
  endtask

  initial begin
    int inh, rts, rts_cyc, start, hp;
    logic [7:0] d;
    logic [10:0] seen, exp;

    bus.tx_data  = '0;
    bus.tx_valid = 1'b0;

    repeat (3) tick();
    chk("rst_ready", {31'd0, bus.tx_ready}, 32'd1);
    chk("rst_clk_oe", {31'd0, bus.ps2_clk_oe}, 32'd0);
    chk("rst_data_oe", {31'd0, bus.ps2_data_oe}, 32'd0);
    chk("rst_done", {31'd0, bus.tx_done}, 32'd0);
    chk("rst_err", {31'd0, bus.tx_err}, 32'd0);
    RSTN = 1'b1;
    repeat (int'($urandom_range(2, 9))) tick();

    full_xfer("ed", 8'hED, 1'b1, 1'b0);
    full_xfer("x01", 8'h01, 1'b1, 1'b0);
    full_xfer("ff_nack", 8'hFF, 1'b0, 1'b1);

    // Device never clocks: the timeout must end the transfer.
    d     = 8'($urandom_range(0, 255));
    start = done_cnt;
    send_req(d);
    wait_rts(inh, rts, rts_cyc);
    chk("to_rts_len", rts, 32'd1);
    wait_done("to_done", start, int'(ToCyc) + 200);
    chk("to_latency", done_cyc - rts_cyc, ToCyc);
    chk("to_err", {31'd0, last_err}, 32'd1);
    chk("to_clk_oe", {31'd0, done_clk_oe}, 32'd0);
    chk("to_data_oe", {31'd0, done_data_oe}, 32'd0);
    tick();
    chk("to_ready_after", {31'd0, bus.tx_ready}, 32'd1);

    // Reset after the fourth falling edge of a random byte.
    d     = 8'($urandom_range(0, 255));
    hp    = int'($urandom_range(3, 12));
    exp   = model_frame(d);
    start = done_cnt;
    send_req(d);
    wait_rts(inh, rts, rts_cyc);
    device_frame(hp, 1'b1, 4, seen);
    chk("rstmid_bits", {27'd0, seen[4:0]}, {27'd0, exp[4:0]});
    RSTN = 1'b0;
    #1;
    chk("rstmid_clk_oe", {31'd0, bus.ps2_clk_oe}, 32'd0);
    chk("rstmid_data_oe", {31'd0, bus.ps2_data_oe}, 32'd0);
    repeat (3) tick();
    RSTN = 1'b1;
    tick();
    chk("rstmid_ready", {31'd0, bus.tx_ready}, 32'd1);
    repeat (50) tick();
    chk("rstmid_no_done", done_cnt - start, 32'd0);

    // A second request during an active transfer must be ignored.
    hp    = int'($urandom_range(3, 12));
    exp   = model_frame(8'hAA);
    start = done_cnt;
    send_req(8'hAA);
    bus.tx_data  = 8'h55;
    bus.tx_valid = 1'b1;
    wait_rts(inh, rts, rts_cyc);
    bus.tx_valid = 1'b0;
    chk("coll_inhibit_len", inh, InhCyc);
    device_frame(hp, 1'b1, 11, seen);
    chk("coll_frame", {21'd0, seen}, {21'd0, exp});
    wait_done("coll_done", start, 100);
    chk("coll_err", {31'd0, last_err}, 32'd0);
    repeat (100) tick();
    chk("coll_one_done", done_cnt - start, 32'd1);
    chk("coll_idle_clk_oe", {31'd0, bus.ps2_clk_oe}, 32'd0);
    chk("coll_idle_ready", {31'd0, bus.tx_ready}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 SHALL have parameter INHIBIT_CYC, default 10000, CLK cycles the PS/2 clock line is held low before the request-to-send (100 us at 100 MHz).
REQ-002 SHALL have parameter TIMEOUT_CYC, default 2000000, maximum CLK cycles from request-to-send to completion.
REQ-003 SHALL have port CLK, input, 1, sole clock; all state changes on its rising edge.
REQ-004 SHALL have port RSTN, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port tx_data, input, 8, byte to send to the device.
REQ-006 SHALL have port tx_valid, input, 1, send request.
REQ-007 SHALL have port tx_ready, output, 1, high when idle and able to accept a byte.
REQ-008 SHALL have port ps2_clk_in, input, 1, debounced PS/2 clock line level.
REQ-009 SHALL have port ps2_data_in, input, 1, debounced PS/2 data line level.
REQ-010 SHALL have port ps2_clk_oe, output, 1, 1 = pull PS/2 clock low; 0 = release it.
REQ-011 SHALL have port ps2_data_oe, output, 1, 1 = pull PS/2 data low; 0 = release it.
REQ-012 SHALL have port tx_done, output, 1, one-cycle pulse at the end of every accepted transfer.
REQ-013 SHALL have port tx_err, output, 1, valid only with tx_done; 1 = NACK or timeout.

Function
REQ-014 SHALL implement states IDLE, INHIBIT, RTS, SEND, ACK, WAIT_IDLE.
REQ-015 SHALL drive tx_ready=1 only in IDLE.
REQ-016 SHALL, when tx_valid and tx_ready, latch tx_data in that cycle and enter INHIBIT on the next cycle.
REQ-017 SHALL ignore tx_valid outside IDLE; the latched byte SHALL NOT change mid-transfer.
REQ-018 SHALL, in INHIBIT, drive ps2_clk_oe=1 and ps2_data_oe=0 for exactly INHIBIT_CYC cycles, then enter RTS.
REQ-019 SHALL, in RTS, drive ps2_clk_oe=1 and ps2_data_oe=1 for exactly 1 cycle, then enter SEND.
REQ-020 SHALL, in SEND, drive ps2_clk_oe=0 and hold ps2_data_oe=1 (start bit 0) until the first falling edge.
REQ-021 SHALL detect a falling edge as the registered previous ps2_clk_in=1 with current ps2_clk_in=0; the previous-value register resets to 1.
REQ-022 SHALL, on the n-th falling edge in SEND (n=1..10), set ps2_data_oe to the inverse of frame bit n.
- n=1..8: tx_data[0]..tx_data[7]
- n=9: odd parity = ~^data
- n=10: stop = 1, so oe=0
REQ-023 SHALL use a 4-bit bit counter and enter ACK immediately after the 10th falling edge.
REQ-024 SHALL, in ACK, keep both oe=0 and sample ps2_data_in on the next falling edge; 0 = ACK, 1 = NACK (recorded).
REQ-025 SHALL, in WAIT_IDLE, wait until ps2_clk_in=1 and ps2_data_in=1 in the same cycle, then pulse tx_done (tx_err = recorded NACK) and return to IDLE.
REQ-026 SHALL ignore falling edges in IDLE, INHIBIT, RTS and WAIT_IDLE.
REQ-027 SHALL count cycles from RTS entry; on reaching TIMEOUT_CYC in any of RTS, SEND, ACK or WAIT_IDLE, it SHALL release both lines, pulse tx_done and tx_err together, and enter IDLE.
REQ-028 SHALL register all outputs; tx_done, tx_err and ps2_*_oe SHALL be glitch-free.

Reset
REQ-029 SHALL, while RSTN=0, asynchronously force state=IDLE, ps2_clk_oe=0, ps2_data_oe=0, tx_done=0, tx_err=0, tx_ready=1, and clear all counters.
REQ-030 SHALL, on reset mid-transfer, release both lines immediately, produce no tx_done pulse, and discard the frame.

Verification
REQ-031 SHALL verify send 0xED with a device model that ACKs:
- clk_oe low for 10000 cycles, then 1 RTS cycle
- data line bits 1,0,1,1,0,1,1,1, parity 1, stop 1
- tx_done=1, tx_err=0
REQ-032 SHALL verify send 0x01: parity bit 0; device ACKs; tx_done=1, tx_err=0.
REQ-033 SHALL verify send 0xFF with the device holding data high at the ACK edge: tx_done=1, tx_err=1.
REQ-034 SHALL verify TIMEOUT_CYC=5000 with the device never clocking: both oe=0, and tx_done=tx_err=1 exactly 5000 cycles after RTS.
REQ-035 SHALL verify RSTN low after the 4th falling edge: both oe=0 in the same cycle, no tx_done, tx_ready=1 after release.
REQ-036 SHALL verify tx_valid with 0x55 during a 0xAA transfer: transmitted bits match 0xAA, and exactly one tx_done occurs.
